// File: rtl/regfile_writeback_queue.sv
// Write-back buffer in front of the register file's single write port: two
// round-robin arbitrated producers, a small FIFO, one drain per cycle, RAW hazard flags.
module regfile_writeback_queue #(
   parameter int unsigned log2regs  = 1,
   parameter int unsigned size      = 32,
   parameter int unsigned log2depth = 2
) (
   input  logic                  CGRA_Clock,
   input  logic                  CGRA_Reset,
   input  logic                  src0_valid,
   output logic                  src0_ready,
   input  logic [log2regs-1:0]   src0_addr,
   input  logic [size-1:0]       src0_data,
   input  logic                  src1_valid,
   output logic                  src1_ready,
   input  logic [log2regs-1:0]   src1_addr,
   input  logic [size-1:0]       src1_data,
   input  logic                  drain_en,
   output logic                  WE0,
   output logic [log2regs-1:0]   address_in0,
   output logic [size-1:0]       wr_data,
   input  logic [log2regs-1:0]   rd_addr0,
   input  logic [log2regs-1:0]   rd_addr1,
   output logic                  pending0,
   output logic                  pending1,
   output logic [log2depth:0]    count,
   output logic                  full,
   output logic                  empty
);

   localparam int unsigned depth = 1 << log2depth;
   localparam int unsigned cnt_w = log2depth + 1;
   localparam int unsigned ptr_w = log2depth;

   logic [log2regs-1:0] mem_addr [depth];
   logic [size-1:0]     mem_data [depth];
   logic [ptr_w-1:0]    wr_ptr;
   logic [ptr_w-1:0]    rd_ptr;
   logic                last_grant;

   logic                grant0_c;
   logic                grant1_c;
   logic                push_c;
   logic                pop_c;
   logic                push_src_c;
   logic [log2regs-1:0] push_addr_c;
   logic [size-1:0]     push_data_c;
   logic [ptr_w-1:0]    idx_c;
   logic                occ_c;

   assign full  = (count == cnt_w'(depth));
   assign empty = (count == '0);

   // Round-robin: on contention the source that did not win last time goes first.
   always_comb begin
      grant0_c    = 1'b0;
      grant1_c    = 1'b0;
      push_src_c  = 1'b0;
      push_addr_c = src0_addr;
      push_data_c = src0_data;
      if (src0_valid && src1_valid) begin
         grant0_c = last_grant;
         grant1_c = ~last_grant;
      end else begin
         grant0_c = src0_valid;
         grant1_c = src1_valid;
      end
      if (grant1_c) begin
         push_src_c  = 1'b1;
         push_addr_c = src1_addr;
         push_data_c = src1_data;
      end
   end

   assign src0_ready = grant0_c & ~full;
   assign src1_ready = grant1_c & ~full;
   assign push_c     = (src0_valid & src0_ready) | (src1_valid & src1_ready);
   assign pop_c      = drain_en & ~empty;

   // Payload storage; entries outside the occupied window are don't-care, so no reset.
   always_ff @(posedge CGRA_Clock) begin
      if (push_c) begin
         mem_addr[wr_ptr] <= push_addr_c;
         mem_data[wr_ptr] <= push_data_c;
      end
   end

   always_ff @(posedge CGRA_Clock or negedge CGRA_Reset) begin
      if (!CGRA_Reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         last_grant <= 1'b1;
      end else begin
         if (push_c) begin
            wr_ptr     <= wr_ptr + ptr_w'(1);
            last_grant <= push_src_c;
         end
         if (pop_c) begin
            rd_ptr <= rd_ptr + ptr_w'(1);
         end
         case ({push_c, pop_c})
            2'b10:   count <= count + cnt_w'(1);
            2'b01:   count <= count - cnt_w'(1);
            default: count <= count;
         endcase
      end
   end

   // Register-file write port; address/data hold when idle.
   always_ff @(posedge CGRA_Clock or negedge CGRA_Reset) begin
      if (!CGRA_Reset) begin
         WE0         <= 1'b0;
         address_in0 <= '0;
         wr_data     <= '0;
      end else begin
         WE0 <= pop_c;
         if (pop_c) begin
            address_in0 <= mem_addr[rd_ptr];
            wr_data     <= mem_data[rd_ptr];
         end
      end
   end

   // The in-flight write is a hazard too: the register file reads before it writes.
   always_comb begin
      pending0 = WE0 && (address_in0 == rd_addr0);
      pending1 = WE0 && (address_in0 == rd_addr1);
      idx_c    = '0;
      occ_c    = 1'b0;
      for (int unsigned i = 0; i < depth; i++) begin
         idx_c = ptr_w'(i);
         occ_c = (cnt_w'(ptr_w'(idx_c - rd_ptr)) < count);
         if (occ_c && (mem_addr[idx_c] == rd_addr0)) pending0 = 1'b1;
         if (occ_c && (mem_addr[idx_c] == rd_addr1)) pending1 = 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Randomized bench for regfile_writeback_queue: queue-based reference model plus
// a scoreboard monitor on the register-file write port.
module tb_regfile_writeback_queue;

   localparam int unsigned AW    = 1;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 4;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } ent_t;

   logic          clk;
   logic          rst_n;
   logic          v0, v1, drain_en;
   logic [AW-1:0] a0, a1, ra0, ra1;
   logic [DW-1:0] d0, d1;
   logic          r0, r1, we, p0, p1, full, empty;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic [2:0]    count;

   int            n_chk;
   int            n_err;
   ent_t          mq[$];
   ent_t          exp_q[$];
   logic          m_last;
   logic          m_we;
   logic [AW-1:0] m_wa;
   logic          hold0, hold1;

   regfile_writeback_queue #(.log2regs(AW), .size(DW), .log2depth(2)) dut (
      .CGRA_Clock(clk), .CGRA_Reset(rst_n),
      .src0_valid(v0), .src0_ready(r0), .src0_addr(a0), .src0_data(d0),
      .src1_valid(v1), .src1_ready(r1), .src1_addr(a1), .src1_data(d1),
      .drain_en(drain_en), .WE0(we), .address_in0(waddr), .wr_data(wdata),
      .rd_addr0(ra0), .rd_addr1(ra1), .pending0(p0), .pending1(p1),
      .count(count), .full(full), .empty(empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic pend(input logic [AW-1:0] ra);
      logic p;
      p = m_we && (m_wa == ra);
      foreach (mq[i]) if (mq[i].addr == ra) p = 1'b1;
      return p;
   endfunction

   // Scoreboard: every register-file write must match the next expected pop.
   task automatic monitor();
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      ent_t          e;
      ea = '0;
      ed = '0;
      forever begin
         @(negedge clk or negedge rst_n);
         if (!rst_n) begin
            ea = '0;
            ed = '0;
            exp_q.delete();
         end else if (we) begin
            if (exp_q.size() == 0) begin
               chk("we_without_expected", 64'(we), 64'(0));
            end else begin
               e  = exp_q.pop_front();
               ea = e.addr;
               ed = e.data;
               chk("wr_addr", 64'(waddr), 64'(ea));
               chk("wr_data", 64'(wdata), 64'(ed));
            end
         end else begin
            chk("hold_addr", 64'(waddr), 64'(ea));
            chk("hold_data", 64'(wdata), 64'(ed));
         end
      end
   endtask

   // One clock of stimulus: drive, compare combinational outputs, advance model.
   task automatic cycle(input int pv0, input int pv1, input int pdr);
      logic full_m, g0, g1, acc0, acc1;
      ent_t e;
      @(negedge clk);
      if (!hold0) begin
         v0 = ($urandom_range(99) < pv0);
         a0 = AW'($urandom);
         d0 = $urandom;
      end
      if (!hold1) begin
         v1 = ($urandom_range(99) < pv1);
         a1 = AW'($urandom);
         d1 = $urandom;
      end
      drain_en = ($urandom_range(99) < pdr);
      ra0 = AW'($urandom);
      ra1 = AW'($urandom);
      #1;
      full_m = (mq.size() == DEPTH);
      g0 = v0 && (!v1 || m_last);
      g1 = v1 && (!v0 || !m_last);
      acc0 = g0 && !full_m;
      acc1 = g1 && !full_m;
      chk("src0_ready", 64'(r0), 64'(acc0));
      chk("src1_ready", 64'(r1), 64'(acc1));
      chk("count", 64'(count), 64'(mq.size()));
      chk("full", 64'(full), 64'(full_m));
      chk("empty", 64'(empty), 64'(mq.size() == 0));
      chk("pending0", 64'(p0), 64'(pend(ra0)));
      chk("pending1", 64'(p1), 64'(pend(ra1)));
      if (drain_en && mq.size() > 0) begin
         e = mq.pop_front();
         exp_q.push_back(e);
         m_we = 1'b1;
         m_wa = e.addr;
      end else begin
         m_we = 1'b0;
      end
      if (acc0) begin
         e.addr = a0; e.data = d0;
         mq.push_back(e);
         m_last = 1'b0;
      end
      if (acc1) begin
         e.addr = a1; e.data = d1;
         mq.push_back(e);
         m_last = 1'b1;
      end
      hold0 = v0 && !acc0;
      hold1 = v1 && !acc1;
   endtask

   task automatic mid_reset();
      @(negedge clk);
      chk("count_pre_reset", 64'(count), 64'(mq.size()));
      #2;
      rst_n = 1'b0;
      #1;
      chk("reset_count", 64'(count), 64'(0));
      chk("reset_we", 64'(we), 64'(0));
      chk("reset_empty", 64'(empty), 64'(1));
      mq.delete();
      m_we = 1'b0; m_last = 1'b1;
      hold0 = 1'b0; hold1 = 1'b0;
      v0 = 1'b0; v1 = 1'b0; drain_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      n_chk = 0; n_err = 0;
      rst_n = 1'b0;
      v0 = 1'b0; v1 = 1'b0; drain_en = 1'b0;
      a0 = '0; a1 = '0; d0 = '0; d1 = '0; ra0 = '0; ra1 = '0;
      m_last = 1'b1; m_we = 1'b0; m_wa = '0;
      hold0 = 1'b0; hold1 = 1'b0;
      fork
         monitor();
      join_none
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2)   cycle(0, 0, 0);
      repeat (20)  cycle(100, 100, 100);
      repeat (8)   cycle(100, 0, 0);
      repeat (10)  cycle(100, 0, 100);
      repeat (10)  cycle(0, 0, 100);
      repeat (3)   cycle(100, 0, 0);
      mid_reset();
      repeat (2)   cycle(0, 0, 0);
      repeat (400) cycle(60, 60, 60);
      repeat (200) cycle(90, 90, 30);
      repeat (12)  cycle(0, 0, 100);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      chk("final_count", 64'(count), 64'(mq.size()));
      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_writeback_queue.md
Name: regfile_writeback_queue

Overview:
Write-back buffer that sits directly upstream of the CGRA register file's single write port (WE0 / address_in0 / in0).
- Accepts {address, data} results from two producers (e.g. FU result and memory load) over valid/ready handshakes, with round-robin arbitration.
- Queues the results in a small FIFO and drains at most one per cycle into the register file.
- Reports per-read-port RAW hazards (pending writes) against the register file's two read addresses.

Parameters:
log2regs, 1, register-file address width (matches register file)
size, 32, data width (matches register file)
log2depth, 2, log2 of FIFO depth; depth = 2**log2depth entries

Ports:
CGRA_Clock  input  1  clock; all state updates on rising edge
CGRA_Reset  input  1  asynchronous, active-low reset (0 = reset asserted)
src0_valid  input  1  source 0 has a result
src0_ready  output  1  source 0 result accepted this cycle when valid&ready
src0_addr  input  log2regs  destination register, source 0
src0_data  input  size  result data, source 0
src1_valid / src1_ready / src1_addr / src1_data  same as source 0, for source 1
drain_en  input  1  1 = allowed to issue a register-file write this cycle
WE0  output  1  register-file write enable (registered)
address_in0  output  log2regs  register-file write address (registered)
wr_data  output  size  register-file write data, drives register file in0 (registered)
rd_addr0, rd_addr1  input  log2regs  register-file read addresses (address_out0/1)
pending0, pending1  output  1  a write to rd_addrN is queued or in flight
count  output  log2depth+1  current FIFO occupancy, 0..depth
full, empty  output  1  count==depth / count==0

Behaviour:
- Reset (CGRA_Reset==0, asynchronous): count=0, read/write pointers=0, WE0=0, address_in0=0, wr_data=0, last_grant=1 (so source 0 has priority first). All queued entries are discarded, including on reset mid-operation; outputs hold reset values until the first edge after release.
- Arbitration (combinational):
  - Only one valid: that source is granted.
  - Both valid: grant the source != last_grant.
  - srcN_ready = grant_N & !full. Ready may depend on valid.
  - At most one enqueue per cycle; the non-granted source sees ready=0 and must hold its valid, addr and data.
- Enqueue: on an edge where srcN_valid & srcN_ready, write {addr, data} at the write pointer, advance the pointer modulo depth, and set last_grant=N.
- Drain: on each edge, pop = drain_en & (count>0). count is the pre-edge value; a same-cycle enqueue is not visible to pop.
  - pop=1: WE0<=1, address_in0/wr_data <= head entry, read pointer advances modulo depth.
  - pop=0: WE0<=0; address_in0 and wr_data hold their previous values.
- Latency: a result accepted at edge k is popped at edge k+1 at the earliest, WE0 is high during cycle k+1..k+2, and the register file commits it at edge k+2.
- Occupancy:
  - Enqueue and pop on the same edge: count unchanged.
  - Enqueue only: count+1. Pop only: count-1.
  - Full blocks enqueue even if a pop occurs in the same cycle (ready is based on pre-edge count).
- Pointers wrap naturally at depth. count never exceeds depth or goes below 0.
- Ordering: strict FIFO. Same-address entries are written in acceptance order.
- Hazards (combinational): pendingN = 1 if any occupied FIFO entry has addr==rd_addrN, or (WE0==1 and address_in0==rd_addrN). The in-flight write counts because the register file samples its read before its write on the same edge.
- full and empty decode combinationally from count.

Test Plan:
- Reset release, no activity -> WE0=0, count=0, empty=1, src0_ready=src1_ready=0, pending0/1=0; drive CGRA_Reset=0 mid-stream with count=3 -> count=0 and WE0=0 immediately (asynchronous).
- Single write: src0 {addr=1, data=0xDEADBEEF} accepted at edge k, drain_en=1 -> WE0=1, address_in0=1, wr_data=0xDEADBEEF during cycle after edge k+1; pending when rd_addr0=1 is high from after edge k until edge k+2.
- Both sources valid every cycle (src0 data 0xA0.., src1 data 0xB0..), drain_en=1 -> grants alternate 0,1,0,1 starting with src0; WE0 data sequence A0,B0,A1,B1.
- drain_en=0, src0 streams 5 entries with depth=4 -> 4 accepted, full=1, src0_ready=0 on the 5th; raise drain_en -> 4 writes in FIFO order with no loss, then the 5th is accepted.
- Simultaneous enqueue and pop with count=2 -> count stays 2; run 10 entries through to exercise pointer wrap -> output order matches input order.
- Two writes to addr 0 (data 5 then 7) -> register-file write order 5 then 7; pending0 (rd_addr0=0) stays high until the edge committing 7.
